// File: rtl/irq_ctrl.sv
// Parametrised interrupt controller: NUM_SRC sources, each with enable, priority
// and edge/level mode, a global threshold, and a claim/complete handshake.
module irq_ctrl #(
    parameter int unsigned          NUM_SRC   = 4,
    parameter int unsigned          PRIO_W    = 2,
    parameter logic [NUM_SRC-1:0]   EDGE_MASK = NUM_SRC'(1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cfg_we,
    input  logic               cfg_re,
    input  logic [5:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               irq_req,
    output logic [5:0]         irq_id,
    input  logic               claim,
    input  logic               complete,
    input  logic [5:0]         complete_id,
    output logic [5:0]         claim_id,
    output logic               in_service
);

    localparam int unsigned ID_W      = 6;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned PRIO_BASE = 8;

    localparam logic [ADDR_W-1:0] ADDR_ENABLE  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_PENDING = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_THRESH  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_CLAIM   = ADDR_W'(3);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    // Architectural state
    state_e                          state_q,     state_d;
    logic [NUM_SRC-1:0]              enable_q,    enable_d;
    logic [NUM_SRC-1:0]              pending_q,   pending_d;
    logic [NUM_SRC-1:0]              src_prev_q,  src_prev_d;
    logic [NUM_SRC-1:0][PRIO_W-1:0]  prio_q,      prio_d;
    logic [PRIO_W-1:0]               thresh_q,    thresh_d;
    logic [ID_W-1:0]                 claim_id_q,  claim_id_d;
    logic                            irq_req_q,   irq_req_d;
    logic [ID_W-1:0]                 irq_id_q,    irq_id_d;
    logic [DATA_W-1:0]               cfg_rdata_q, cfg_rdata_d;

    // Internal combinational terms
    logic                            claim_acc;
    logic                            complete_acc;
    logic [NUM_SRC-1:0]              rise;
    logic [NUM_SRC-1:0]              claim_clr;
    logic [NUM_SRC-1:0]              eligible;
    logic                            found;
    logic [PRIO_W-1:0]               best_prio;
    logic [ID_W-1:0]                 win_id;
    logic [DATA_W-1:0]               rd_val;
    logic                            unused_wdata;

    // Upper write-data bits are architecturally ignored
    assign unused_wdata = ^cfg_wdata;

    // Handshake FSM: IDLE accepts a claim of the live request, BUSY waits for a matching complete
    always_comb begin
        state_d      = state_q;
        claim_id_d   = claim_id_q;
        claim_acc    = 1'b0;
        complete_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (claim && irq_req_q) begin
                    claim_acc  = 1'b1;
                    claim_id_d = irq_id_q;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (complete && (complete_id == claim_id_q)) begin
                    complete_acc = 1'b1;
                    claim_id_d   = '0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                claim_id_d = '0;
            end
        endcase
    end

    // Configuration register writes
    always_comb begin
        enable_d = enable_q;
        thresh_d = thresh_q;
        prio_d   = prio_q;
        if (cfg_we) begin
            if (cfg_addr == ADDR_ENABLE) begin
                enable_d = cfg_wdata[NUM_SRC-1:0];
            end
            if (cfg_addr == ADDR_THRESH) begin
                thresh_d = cfg_wdata[PRIO_W-1:0];
            end
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (cfg_addr == ADDR_W'(int'(PRIO_BASE) + i)) begin
                    prio_d[i] = cfg_wdata[PRIO_W-1:0];
                end
            end
        end
    end

    // Pending capture: edge sources latch rises until claimed (set beats clear), level sources follow the line
    always_comb begin
        src_prev_d = irq_src;
        rise       = irq_src & ~src_prev_q;
        claim_clr  = '0;
        pending_d  = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            claim_clr[i] = claim_acc && (irq_id_q == ID_W'(i + 1));
            if (EDGE_MASK[i]) begin
                pending_d[i] = rise[i] | (pending_q[i] & ~claim_clr[i]);
            end else begin
                pending_d[i] = irq_src[i];
            end
        end
    end

    // Arbitration: highest priority above threshold wins, lowest index breaks ties
    always_comb begin
        eligible  = '0;
        found     = 1'b0;
        best_prio = '0;
        win_id    = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            eligible[i] = pending_q[i] & enable_q[i] & (prio_q[i] > thresh_q);
            if (eligible[i] && (!found || (prio_q[i] > best_prio))) begin
                found     = 1'b1;
                best_prio = prio_q[i];
                win_id    = ID_W'(i + 1);
            end
        end
        irq_req_d = found && (state_q == S_IDLE);
        irq_id_d  = irq_req_d ? win_id : '0;
    end

    // Register read mux; the captured value holds until the next read strobe
    always_comb begin
        rd_val = '0;
        case (cfg_addr)
            ADDR_ENABLE:  rd_val = DATA_W'(enable_q);
            ADDR_PENDING: rd_val = DATA_W'(pending_q);
            ADDR_THRESH:  rd_val = DATA_W'(thresh_q);
            ADDR_CLAIM:   rd_val = DATA_W'(claim_id_q);
            default: begin
                for (int i = 0; i < int'(NUM_SRC); i++) begin
                    if (cfg_addr == ADDR_W'(int'(PRIO_BASE) + i)) begin
                        rd_val = DATA_W'(prio_q[i]);
                    end
                end
            end
        endcase
        cfg_rdata_d = cfg_re ? rd_val : cfg_rdata_q;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            enable_q    <= '0;
            pending_q   <= '0;
            src_prev_q  <= '0;
            prio_q      <= '0;
            thresh_q    <= '0;
            claim_id_q  <= '0;
            irq_req_q   <= 1'b0;
            irq_id_q    <= '0;
            cfg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            pending_q   <= pending_d;
            src_prev_q  <= src_prev_d;
            prio_q      <= prio_d;
            thresh_q    <= thresh_d;
            claim_id_q  <= claim_id_d;
            irq_req_q   <= irq_req_d;
            irq_id_q    <= irq_id_d;
            cfg_rdata_q <= cfg_rdata_d;
        end
    end

    assign cfg_rdata  = cfg_rdata_q;
    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign claim_id   = claim_id_q;
    assign in_service = (state_q == S_BUSY);

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: vector table for arbitration plus hand sequences
// for the handshake, edge capture and reset corners.
module tb_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_src;
    logic        cfg_we;
    logic        cfg_re;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        irq_req;
    logic [5:0]  irq_id;
    logic        claim;
    logic        complete;
    logic [5:0]  complete_id;
    logic [5:0]  claim_id;
    logic        in_service;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [3:0]  en;
        logic [1:0]  thr;
        logic [7:0]  prio;   // {p3,p2,p1,p0}
        logic [3:0]  src;
        logic        exp_req;
        logic [5:0]  exp_id;
    } vec_t;
    vec_t vecs[9];

    irq_ctrl #(
        .NUM_SRC  (4),
        .PRIO_W   (2),
        .EDGE_MASK(4'b0001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .cfg_we     (cfg_we),
        .cfg_re     (cfg_re),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .claim      (claim),
        .complete   (complete),
        .complete_id(complete_id),
        .claim_id   (claim_id),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [5:0] addr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Read goes through the scoreboard: expectation queued with the strobe, popped when rdata lands
    task automatic cfg_read(input logic [5:0] addr, input logic [31:0] exp, input string name);
        sb_t e;
        cfg_re   = 1'b1;
        cfg_addr = addr;
        sb_q.push_back('{name: name, exp: exp});
        tick();
        cfg_re = 1'b0;
        e = sb_q.pop_front();
        check(e.name, cfg_rdata, e.exp);
    endtask

    task automatic pulse_claim();
        claim = 1'b1;
        tick();
        claim = 1'b0;
    endtask

    task automatic pulse_complete(input logic [5:0] id);
        complete    = 1'b1;
        complete_id = id;
        tick();
        complete    = 1'b0;
    endtask

    task automatic apply_cfg(input logic [3:0] en, input logic [1:0] thr, input logic [7:0] prio);
        logic [7:0] p;
        p = prio;
        cfg_write(6'h00, 32'(en));
        cfg_write(6'h02, 32'(thr));
        for (int k = 0; k < 4; k++) begin
            cfg_write(6'(8 + k), 32'(p[2*k +: 2]));
        end
    endtask

    initial begin
        sb_t e;
        rst = 1'b0; irq_src = '0; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0;
        cfg_wdata = '0; claim = 1'b0; complete = 1'b0; complete_id = '0;

        vecs[0] = '{en: 4'b1110, thr: 2'd0, prio: 8'b11_11_01_00, src: 4'b1110, exp_req: 1'b1, exp_id: 6'd3};
        vecs[1] = '{en: 4'b1110, thr: 2'd0, prio: 8'b11_01_01_00, src: 4'b1110, exp_req: 1'b1, exp_id: 6'd4};
        vecs[2] = '{en: 4'b1110, thr: 2'd3, prio: 8'b11_11_11_00, src: 4'b1110, exp_req: 1'b0, exp_id: 6'd0};
        vecs[3] = '{en: 4'b1110, thr: 2'd1, prio: 8'b01_10_10_00, src: 4'b1110, exp_req: 1'b1, exp_id: 6'd2};
        vecs[4] = '{en: 4'b0100, thr: 2'd0, prio: 8'b11_11_11_00, src: 4'b1110, exp_req: 1'b1, exp_id: 6'd3};
        vecs[5] = '{en: 4'b1110, thr: 2'd0, prio: 8'b00_00_00_00, src: 4'b1110, exp_req: 1'b0, exp_id: 6'd0};
        vecs[6] = '{en: 4'b1110, thr: 2'd0, prio: 8'b01_00_00_00, src: 4'b1000, exp_req: 1'b1, exp_id: 6'd4};
        vecs[7] = '{en: 4'b1000, thr: 2'd0, prio: 8'b11_11_11_00, src: 4'b0110, exp_req: 1'b0, exp_id: 6'd0};
        vecs[8] = '{en: 4'b1110, thr: 2'd1, prio: 8'b10_01_01_00, src: 4'b1110, exp_req: 1'b1, exp_id: 6'd4};

        tick(); tick();
        rst = 1'b1;
        tick();

        // Reset state
        check("rst_irq_req", 32'(irq_req), 32'd0);
        check("rst_in_service", 32'(in_service), 32'd0);
        cfg_read(6'h00, 32'd0, "rst_enable");
        cfg_read(6'h02, 32'd0, "rst_thresh");
        cfg_read(6'h08, 32'd0, "rst_prio0");

        // Edge capture and claim on source 0
        cfg_write(6'h08, 32'd2);
        cfg_write(6'h02, 32'd1);
        cfg_write(6'h00, 32'd1);
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        check("edge_req_not_yet", 32'(irq_req), 32'd0);
        cfg_read(6'h01, 32'd1, "edge_pending_set");
        check("edge_req", 32'(irq_req), 32'd1);
        check("edge_id", 32'(irq_id), 32'd1);
        pulse_claim();
        check("claim_id", 32'(claim_id), 32'd1);
        check("claim_in_service", 32'(in_service), 32'd1);
        tick();
        check("claim_req_drop", 32'(irq_req), 32'd0);
        check("claim_id_drop", 32'(irq_id), 32'd0);
        cfg_read(6'h01, 32'd0, "claim_pending_clr");
        cfg_read(6'h03, 32'd1, "claim_reg");

        // Handshake misuse
        pulse_complete(6'd2);
        check("bad_complete_busy", 32'(in_service), 32'd1);
        pulse_claim();
        check("claim_in_busy", 32'(claim_id), 32'd1);
        pulse_complete(6'd1);
        check("complete_ok", 32'(in_service), 32'd0);
        check("complete_claim_id", 32'(claim_id), 32'd0);
        pulse_complete(6'd1);
        check("complete_in_idle", 32'(in_service), 32'd0);
        pulse_claim();
        check("claim_no_req_svc", 32'(in_service), 32'd0);
        check("claim_no_req_id", 32'(claim_id), 32'd0);

        // Edge re-pulse on the claim cycle: set wins, request returns after complete
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        tick();
        check("repulse_req", 32'(irq_req), 32'd1);
        claim   = 1'b1;
        irq_src = 4'b0001;
        tick();
        claim   = 1'b0;
        irq_src = 4'b0000;
        tick();
        check("repulse_busy", 32'(in_service), 32'd1);
        check("repulse_req_off", 32'(irq_req), 32'd0);
        cfg_read(6'h01, 32'd1, "repulse_pending");
        pulse_complete(6'd1);
        check("repulse_idle", 32'(in_service), 32'd0);
        check("repulse_req_lag", 32'(irq_req), 32'd0);
        tick();
        check("repulse_req_back", 32'(irq_req), 32'd1);
        check("repulse_id_back", 32'(irq_id), 32'd1);
        pulse_claim();
        tick();
        pulse_complete(6'd1);
        cfg_read(6'h01, 32'd0, "repulse_pending_clr");

        // Arbitration vector table with level sources 1..3
        for (int v = 0; v < 9; v++) begin
            irq_src = vecs[v].src;
            apply_cfg(vecs[v].en, vecs[v].thr, vecs[v].prio);
            tick(); tick();
            check($sformatf("vec%0d_req", v), 32'(irq_req), 32'(vecs[v].exp_req));
            check($sformatf("vec%0d_id", v), 32'(irq_id), 32'(vecs[v].exp_id));
            cfg_read(6'h01, 32'(vecs[v].src), $sformatf("vec%0d_pending", v));
        end

        // Priority rewrite: winner moves two cycles after the write strobe
        irq_src = 4'b1110;
        apply_cfg(4'b1110, 2'd0, 8'b11_11_01_00);
        tick(); tick();
        check("prio_before", 32'(irq_id), 32'd3);
        cfg_write(6'h0A, 32'd1);
        check("prio_write_edge", 32'(irq_id), 32'd3);
        tick();
        check("prio_after", 32'(irq_id), 32'd4);
        cfg_read(6'h0A, 32'd1, "prio2_readback");

        // Disable drops the request one cycle after the write takes effect
        cfg_write(6'h00, 32'd0);
        check("disable_edge", 32'(irq_req), 32'd1);
        tick();
        check("disable_req", 32'(irq_req), 32'd0);

        // Disabling after a claim leaves service untouched
        cfg_write(6'h00, 32'hFFFF_FFFF);
        tick();
        check("reenable_req", 32'(irq_req), 32'd1);
        cfg_read(6'h00, 32'h0000_000F, "enable_upper_bits");
        pulse_claim();
        check("claim_src3", 32'(claim_id), 32'd4);
        cfg_write(6'h00, 32'd0);
        tick();
        check("disable_keeps_svc", 32'(in_service), 32'd1);
        cfg_write(6'h00, 32'hF);
        tick();

        // Asynchronous reset mid-service
        #2;
        rst = 1'b0;
        #1;
        check("arst_req", 32'(irq_req), 32'd0);
        check("arst_id", 32'(irq_id), 32'd0);
        check("arst_claim_id", 32'(claim_id), 32'd0);
        check("arst_in_service", 32'(in_service), 32'd0);
        irq_src = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
        cfg_read(6'h00, 32'd0, "arst_enable");
        cfg_read(6'h01, 32'd0, "arst_pending");
        cfg_read(6'h02, 32'd0, "arst_thresh");
        cfg_read(6'h03, 32'd0, "arst_claim");
        cfg_read(6'h0B, 32'd0, "arst_prio3");

        // Simultaneous write and read returns the old value
        cfg_we    = 1'b1;
        cfg_re    = 1'b1;
        cfg_addr  = 6'h02;
        cfg_wdata = 32'd2;
        sb_q.push_back('{name: "rw_same_cycle", exp: 32'd0});
        tick();
        cfg_we = 1'b0;
        cfg_re = 1'b0;
        e = sb_q.pop_front();
        check(e.name, cfg_rdata, e.exp);
        cfg_read(6'h02, 32'd2, "rw_new_value");

        // Unused addresses read zero and ignore writes
        cfg_write(6'h3F, 32'hDEAD_BEEF);
        cfg_read(6'h3F, 32'd0, "unused_3f");
        cfg_read(6'h04, 32'd0, "unused_04");

        // rdata holds without a read strobe
        cfg_addr = 6'h02;
        tick();
        check("rdata_hold", cfg_rdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
